// File: rtl/fp16_pkg.sv
// FP16 (1-5-10, bias 15) format definitions shared by the SFU FP16 datapaths.
package fp16_pkg;

    localparam int unsigned EXP_BITS = 5;
    localparam int unsigned MAN_BITS = 10;
    localparam int unsigned BIAS     = 15;
    localparam int unsigned SIG_BITS = MAN_BITS + 1;

    typedef struct packed {
        logic                sign;
        logic [EXP_BITS-1:0] exponent;
        logic [MAN_BITS-1:0] mantissa;
    } fp16_t;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    // Subnormals are classed as ZERO: the SFU datapaths flush them.
    function automatic fp_class_e classify(input fp16_t x);
        fp_class_e cls;
        cls = NORMAL;
        if (x.exponent == '0) begin
            cls = ZERO;
        end else if (x.exponent == '1) begin
            cls = (x.mantissa == '0) ? INF : NAN;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp16_rne_shift.sv
// Right shift of a significand by i_amt with round-to-nearest-even on the
// discarded bits. i_amt must be >= 1; shifts past W+1 give zero outright.
module fp16_rne_shift
    import fp16_pkg::*;
#(
    parameter int unsigned W     = SIG_BITS,
    parameter int unsigned AMT_W = 7
) (
    input  logic [W-1:0]     i_sig,
    input  logic [AMT_W-1:0] i_amt,
    output logic [W-1:0]     o_mag
);

    localparam int unsigned KMAX = W + 1;

    logic [W-1:0] w_shifted;
    logic         w_guard;
    logic         w_sticky;
    logic         w_round_up;

    // Truncated quotient plus guard (first dropped bit) and sticky (the rest).
    always_comb begin
        w_shifted = i_sig >> i_amt;
        w_guard   = 1'b0;
        w_sticky  = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            if (AMT_W'(i + 1) == i_amt) begin
                w_guard = i_sig[i];
            end else if (AMT_W'(i + 1) < i_amt) begin
                w_sticky = w_sticky | i_sig[i];
            end
        end
        w_round_up = w_guard && (w_sticky || w_shifted[0]);
        if (i_amt > AMT_W'(KMAX)) begin
            w_shifted  = '0;
            w_round_up = 1'b0;
        end
        o_mag = w_shifted + W'(w_round_up);
    end

endmodule

// File: rtl/fp16_to_fixed_conv.sv
// Two-stage streaming FP16 -> signed fixed-point converter with RNE rounding,
// saturation and per-result overflow/invalid flags.
module fp16_to_fixed_conv
    import fp16_pkg::*;
#(
    parameter int unsigned INT_WIDTH = 16,
    parameter int unsigned FRAC_BITS = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [15:0]          in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [INT_WIDTH-1:0] out_data_o,
    output logic                 out_ovf_o,
    output logic                 out_inv_o
);

    // Magnitude must hold INT_WIDTH+1 bits and any right-shifted, rounded significand.
    localparam int unsigned MAG_W  = (INT_WIDTH + 1 > SIG_BITS + 1) ? INT_WIDTH + 1 : SIG_BITS + 1;
    localparam int unsigned SH_W   = 7;
    localparam int          SH_OFS = int'(BIAS + MAN_BITS) - int'(FRAC_BITS);
    localparam int          SH_MAX = int'(INT_WIDTH) - int'(SIG_BITS);

    localparam logic [MAG_W-1:0]     POS_LIM = (MAG_W'(1) << (INT_WIDTH - 1)) - MAG_W'(1);
    localparam logic [MAG_W-1:0]     NEG_LIM = MAG_W'(1) << (INT_WIDTH - 1);
    localparam logic [INT_WIDTH-1:0] MAX_POS = {1'b0, {(INT_WIDTH - 1){1'b1}}};
    localparam logic [INT_WIDTH-1:0] MIN_NEG = {1'b1, {(INT_WIDTH - 1){1'b0}}};

    // ---------------- handshake ----------------
    logic w_stall2;
    logic w_load2;

    logic                    r_v1;
    logic                    r_sign1;
    logic [SIG_BITS-1:0]     r_sig1;
    fp_class_e               r_cls1;
    logic signed [SH_W-1:0]  r_sh1;

    logic                    r_out_valid;
    logic [INT_WIDTH-1:0]    r_out_data;
    logic                    r_out_ovf;
    logic                    r_out_inv;

    assign w_stall2   = r_out_valid && !out_ready_i;
    assign w_load2    = !w_stall2;
    assign in_ready_o = !r_v1 || w_load2;

    // ---------------- S1: unpack ----------------
    fp16_t                  w_in;
    fp_class_e              w_cls;
    logic signed [SH_W-1:0] w_sh;

    assign w_in  = fp16_t'(in_data_i);
    assign w_cls = classify(w_in);
    assign w_sh  = SH_W'(int'(w_in.exponent) - SH_OFS);

    // S1 register: advances whenever S2 takes its contents or it is empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v1    <= 1'b0;
            r_sign1 <= 1'b0;
            r_sig1  <= '0;
            r_cls1  <= ZERO;
            r_sh1   <= '0;
        end else if (in_ready_o) begin
            r_v1 <= in_valid_i;
            if (in_valid_i) begin
                r_sign1 <= w_in.sign;
                r_sig1  <= {1'b1, w_in.mantissa};
                r_cls1  <= w_cls;
                r_sh1   <= w_sh;
            end
        end
    end

    // ---------------- S2: shift / round / saturate ----------------
    logic                 w_sh_neg;
    logic [SH_W-1:0]      w_amt;
    logic                 w_force_ovf;
    logic [MAG_W-1:0]     w_mag_left;
    logic [SIG_BITS-1:0]  w_mag_right;
    logic [MAG_W-1:0]     w_mag;
    logic [MAG_W-1:0]     w_lim;
    logic [INT_WIDTH-1:0] w_mag_t;

    assign w_sh_neg    = r_sh1[SH_W-1];
    assign w_amt       = SH_W'(-r_sh1);
    assign w_force_ovf = !w_sh_neg && (int'(r_sh1) > SH_MAX);
    assign w_mag_left  = MAG_W'(r_sig1) << r_sh1[SH_W-2:0];

    fp16_rne_shift #(
        .W     (SIG_BITS),
        .AMT_W (SH_W)
    ) u_rne_shift (
        .i_sig (r_sig1),
        .i_amt (w_amt),
        .o_mag (w_mag_right)
    );

    assign w_mag   = w_sh_neg ? MAG_W'(w_mag_right) : w_mag_left;
    assign w_lim   = r_sign1 ? NEG_LIM : POS_LIM;
    assign w_mag_t = w_mag[INT_WIDTH-1:0];

    logic [INT_WIDTH-1:0] w_res_data;
    logic                 w_res_ovf;
    logic                 w_res_inv;

    // Result selection per operand class; negative limit allows exactly -2^(W-1).
    always_comb begin
        w_res_data = '0;
        w_res_ovf  = 1'b0;
        w_res_inv  = 1'b0;
        case (r_cls1)
            NAN: begin
                w_res_inv = 1'b1;
            end
            INF: begin
                w_res_ovf  = 1'b1;
                w_res_data = r_sign1 ? MIN_NEG : MAX_POS;
            end
            NORMAL: begin
                if (w_force_ovf || (w_mag > w_lim)) begin
                    w_res_ovf  = 1'b1;
                    w_res_data = r_sign1 ? MIN_NEG : MAX_POS;
                end else begin
                    w_res_data = r_sign1 ? (~w_mag_t + INT_WIDTH'(1)) : w_mag_t;
                end
            end
            default: begin
                w_res_data = '0;
            end
        endcase
    end

    // Output register: holds while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_inv   <= 1'b0;
        end else if (w_load2) begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_out_data <= w_res_data;
                r_out_ovf  <= w_res_ovf;
                r_out_inv  <= w_res_inv;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_ovf_o   = r_out_ovf;
    assign out_inv_o   = r_out_inv;

endmodule
